// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: FSM state encoding, grant IDs and default bus widths.
package sram_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 18;
    localparam int unsigned DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_BOOT = 2'd1,
        GNT_EXE  = 2'd2,
        GNT_IF   = 2'd3
    } gnt_t;

endpackage

// File: rtl/sram_grant_sel.sv
// Combinational request picker. boot always wins; exe vs if is fixed priority, or
// round-robin on the last winner when SRAM_ARB_RR_EN is defined.
module sram_grant_sel
    import sram_arbiter_pkg::*;
(
    input  logic       i_boot_req,
    input  logic       i_exe_req,
    input  logic       i_if_req,
`ifdef SRAM_ARB_RR_EN
    input  logic       i_last_if,
`endif
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = GNT_NONE;
        if (i_boot_req) begin
            o_gnt = GNT_BOOT;
        end else if (i_exe_req && i_if_req) begin
`ifdef SRAM_ARB_RR_EN
            o_gnt = i_last_if ? GNT_EXE : GNT_IF;
`else
            o_gnt = GNT_EXE;
`endif
        end else if (i_exe_req) begin
            o_gnt = GNT_EXE;
        end else if (i_if_req) begin
            o_gnt = GNT_IF;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates boot/exe/if requesters onto one async SRAM and sequences each access
// (ADDR, STROBE, DONE). Optional round-robin between exe and if via SRAM_ARB_RR_EN.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W        = DEF_ADDR_W,
    parameter int unsigned DATA_W        = DEF_DATA_W,
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_req,
    input  logic [ADDR_W-1:0] boot_addr,
    input  logic [DATA_W-1:0] boot_data,
    output logic              boot_ack,
    input  logic              exe_req,
    input  logic              exe_we,
    input  logic [ADDR_W-1:0] exe_addr,
    input  logic [DATA_W-1:0] exe_wdata,
    output logic              exe_ack,
    output logic [DATA_W-1:0] exe_rdata,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_en,
    output logic              sram_oe,
    output logic              sram_we,
    output logic              busy
);

    localparam logic [2:0] CNT_INIT = 3'(STROBE_CYCLES - 1);

    state_t            r_state;
    gnt_t              r_gnt;
    logic [2:0]        r_cnt;
    logic              r_wr;
    logic              r_drive;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic              r_en;
    logic              r_oe;
    logic              r_we_n;
    logic              r_busy;
    logic              r_boot_ack;
    logic              r_exe_ack;
    logic              r_if_ack;
    logic [DATA_W-1:0] r_exe_rdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [1:0]        w_gnt_raw;
    gnt_t              w_gnt;
`ifdef SRAM_ARB_RR_EN
    logic              r_last_if;
`endif

    sram_grant_sel u_grant_sel (
        .i_boot_req (boot_req),
        .i_exe_req  (exe_req),
        .i_if_req   (if_req),
`ifdef SRAM_ARB_RR_EN
        .i_last_if  (r_last_if),
`endif
        .o_gnt      (w_gnt_raw)
    );

    assign w_gnt = gnt_t'(w_gnt_raw);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt       <= GNT_NONE;
            r_cnt       <= '0;
            r_wr        <= 1'b0;
            r_drive     <= 1'b0;
            r_wdata     <= '0;
            r_addr      <= '0;
            r_en        <= 1'b1;
            r_oe        <= 1'b1;
            r_we_n      <= 1'b1;
            r_busy      <= 1'b0;
            r_boot_ack  <= 1'b0;
            r_exe_ack   <= 1'b0;
            r_if_ack    <= 1'b0;
            r_exe_rdata <= '0;
            r_if_rdata  <= '0;
`ifdef SRAM_ARB_RR_EN
            r_last_if   <= 1'b1;
`endif
        end else begin
            r_boot_ack <= 1'b0;
            r_exe_ack  <= 1'b0;
            r_if_ack   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt != GNT_NONE) begin
                        r_gnt   <= w_gnt;
                        r_state <= ADDR;
                        r_busy  <= 1'b1;
                        r_en    <= 1'b0;
                        case (w_gnt)
                            GNT_BOOT: begin
                                r_addr  <= boot_addr;
                                r_wdata <= boot_data;
                                r_wr    <= 1'b1;
                                r_drive <= 1'b1;
                            end
                            GNT_EXE: begin
                                r_addr  <= exe_addr;
                                r_wdata <= exe_wdata;
                                r_wr    <= exe_we;
                                r_drive <= exe_we;
                            end
                            default: begin
                                r_addr  <= if_addr;
                                r_wr    <= 1'b0;
                                r_drive <= 1'b0;
                            end
                        endcase
`ifdef SRAM_ARB_RR_EN
                        if (w_gnt == GNT_EXE) begin
                            r_last_if <= 1'b0;
                        end else if (w_gnt == GNT_IF) begin
                            r_last_if <= 1'b1;
                        end
`endif
                    end
                end
                ADDR: begin
                    r_state <= STROBE;
                    r_cnt   <= CNT_INIT;
                    if (r_wr) begin
                        r_we_n <= 1'b0;
                    end else begin
                        r_oe <= 1'b0;
                    end
                end
                STROBE: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= DONE;
                        r_oe    <= 1'b1;
                        r_we_n  <= 1'b1;
                        // Read data is sampled while OE is still low on this final edge.
                        if (!r_wr && r_gnt == GNT_IF) begin
                            r_if_rdata <= sram_data;
                        end else if (!r_wr && r_gnt == GNT_EXE) begin
                            r_exe_rdata <= sram_data;
                        end
                        r_boot_ack <= (r_gnt == GNT_BOOT);
                        r_exe_ack  <= (r_gnt == GNT_EXE);
                        r_if_ack   <= (r_gnt == GNT_IF);
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_en    <= 1'b1;
                    r_drive <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sram_data = r_drive ? r_wdata : {DATA_W{1'bz}};
    assign sram_addr = r_addr;
    assign sram_en   = r_en;
    assign sram_oe   = r_oe;
    assign sram_we   = r_we_n;
    assign busy      = r_busy;
    assign boot_ack  = r_boot_ack;
    assign exe_ack   = r_exe_ack;
    assign if_ack    = r_if_ack;
    assign exe_rdata = r_exe_rdata;
    assign if_rdata  = r_if_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small SRAM model; expectations follow SRAM_ARB_RR_EN.
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        boot_req;
    logic [17:0] boot_addr;
    logic [15:0] boot_data;
    logic        boot_ack;
    logic        exe_req;
    logic        exe_we;
    logic [17:0] exe_addr;
    logic [15:0] exe_wdata;
    logic        exe_ack;
    logic [15:0] exe_rdata;
    logic        if_req;
    logic [17:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic [17:0] sram_addr;
    wire  [15:0] sram_data;
    logic        sram_en;
    logic        sram_oe;
    logic        sram_we;
    logic        busy;

    logic        mem_init;
    logic [15:0] mem [0:255];

    int n_checks;
    int n_errors;

    sram_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .boot_req  (boot_req),
        .boot_addr (boot_addr),
        .boot_data (boot_data),
        .boot_ack  (boot_ack),
        .exe_req   (exe_req),
        .exe_we    (exe_we),
        .exe_addr  (exe_addr),
        .exe_wdata (exe_wdata),
        .exe_ack   (exe_ack),
        .exe_rdata (exe_rdata),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .sram_en   (sram_en),
        .sram_oe   (sram_oe),
        .sram_we   (sram_we),
        .busy      (busy)
    );

    // Released bus floats high so high-Z is observable as 16'hFFFF.
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (sram_data[g]);
    end

    assign sram_data = (!sram_en && !sram_oe && sram_we) ? mem[sram_addr[7:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= 16'hA000 + 16'(i);
            end
            mem[8'h23] <= 16'hBEEF;
        end else if (!sram_en && !sram_we) begin
            mem[sram_addr[7:0]] <= sram_data;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int ord [4];
    int acyc [4];
    int na;
    int n_if;
    int n_exe;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        mem_init  = 1'b1;
        boot_req  = 1'b0;
        boot_addr = '0;
        boot_data = '0;
        exe_req   = 1'b0;
        exe_we    = 1'b0;
        exe_addr  = '0;
        exe_wdata = '0;
        if_req    = 1'b0;
        if_addr   = '0;
        tick();
        tick();
        rst      = 1'b0;
        mem_init = 1'b0;

        // Reset state
        check_eq("rst_busy", busy, 0);
        check_eq("rst_acks", {boot_ack, exe_ack, if_ack}, 0);
        check_eq("rst_strobes", {sram_en, sram_oe, sram_we}, 3'b111);
        check_eq("rst_addr", sram_addr, 0);
        check_eq("rst_rdata", {exe_rdata, if_rdata}, 0);
        check_eq("rst_bus_z", sram_data, 16'hFFFF);

        // Single EXE read; cycle 0 is this IDLE cycle
        exe_req  = 1'b1;
        exe_we   = 1'b0;
        exe_addr = 18'h00123;
        tick();
        check_eq("rd_c1_ctl", {busy, sram_en, sram_oe, sram_we}, 4'b1011);
        check_eq("rd_c1_addr", sram_addr, 18'h00123);
        tick();
        check_eq("rd_c2_oe", {sram_oe, exe_ack}, 2'b00);
        tick();
        check_eq("rd_c3_oe", {sram_oe, exe_ack}, 2'b00);
        tick();
        check_eq("rd_c4_ack", {exe_ack, sram_oe, sram_en}, 3'b110);
        check_eq("rd_c4_data", exe_rdata, 16'hBEEF);
        exe_req = 1'b0;
        tick();
        check_eq("rd_c5_idle", {exe_ack, busy, sram_en}, 3'b001);
        check_eq("rd_hold", exe_rdata, 16'hBEEF);

        // Single boot write, req dropped after grant
        boot_req  = 1'b1;
        boot_addr = 18'h00010;
        boot_data = 16'h1234;
        tick();
        boot_req = 1'b0;
        check_eq("wr_c1_data", sram_data, 16'h1234);
        check_eq("wr_c1_we", sram_we, 1);
        tick();
        check_eq("wr_c2_we", {sram_we, sram_oe}, 2'b01);
        check_eq("wr_c2_data", sram_data, 16'h1234);
        tick();
        check_eq("wr_c3_we", sram_we, 0);
        tick();
        check_eq("wr_c4_ack", {boot_ack, sram_we, sram_en}, 3'b110);
        check_eq("wr_c4_hold", sram_data, 16'h1234);
        tick();
        check_eq("wr_c5_bus_z", sram_data, 16'hFFFF);
        check_eq("wr_mem", mem[8'h10], 16'h1234);

        // Reset in the middle of an EXE write strobe
        exe_req   = 1'b1;
        exe_we    = 1'b1;
        exe_addr  = 18'h00020;
        exe_wdata = 16'h5555;
        tick();
        exe_req = 1'b0;
        tick();
        check_eq("rst_mid_we_low", sram_we, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_mid_ctl", {sram_we, sram_en, busy, exe_ack}, 4'b1100);
        check_eq("rst_mid_bus_z", sram_data, 16'hFFFF);
        tick();
        check_eq("rst_mid_no_ack", {exe_ack, busy}, 0);

        // Contention: all three held; each drops after its own ack
        boot_addr = 18'h00040;
        boot_data = 16'h4444;
        exe_we    = 1'b0;
        exe_addr  = 18'h00007;
        if_addr   = 18'h00005;
        boot_req  = 1'b1;
        exe_req   = 1'b1;
        if_req    = 1'b1;
        na        = 0;
        for (int c = 0; c < 40 && na < 3; c++) begin
            tick();
            check_eq("cont_one_ack", 32'(boot_ack) + 32'(exe_ack) + 32'(if_ack) <= 1, 1);
            check_eq("cont_strobe_excl", sram_oe | sram_we, 1);
            if (boot_ack) begin ord[na] = 1; acyc[na] = c; na++; boot_req = 1'b0; end
            if (exe_ack)  begin ord[na] = 2; acyc[na] = c; na++; exe_req = 1'b0; end
            if (if_ack)   begin ord[na] = 3; acyc[na] = c; na++; if_req = 1'b0; end
        end
        boot_req = 1'b0;
        exe_req  = 1'b0;
        if_req   = 1'b0;
        check_eq("cont_count", na, 3);
        if (na == 3) begin
            check_eq("cont_order", {ord[0][1:0], ord[1][1:0], ord[2][1:0]}, 6'b01_10_11);
            check_eq("cont_gap", acyc[1] - acyc[0], 5);
        end
        check_eq("cont_if_rdata", if_rdata, 16'hA005);
        check_eq("cont_exe_rdata", exe_rdata, 16'hA007);
        check_eq("cont_mem", mem[8'h40], 16'h4444);
        tick();

        // exe and if both held continuously
        exe_req  = 1'b1;
        exe_addr = 18'h00023;
        if_req   = 1'b1;
        na       = 0;
        for (int c = 0; c < 40 && na < 4; c++) begin
            tick();
            if (exe_ack) begin ord[na] = 2; na++; end
            if (if_ack)  begin ord[na] = 3; na++; end
            if (na == 4) begin exe_req = 1'b0; if_req = 1'b0; end
        end
        exe_req = 1'b0;
        if_req  = 1'b0;
        check_eq("arb_count", na, 4);
`ifdef SRAM_ARB_RR_EN
        check_eq("arb_rr_order", {ord[0][1:0], ord[1][1:0], ord[2][1:0], ord[3][1:0]},
                 8'b10_11_10_11);
`else
        check_eq("arb_fixed_order", {ord[0][1:0], ord[1][1:0], ord[2][1:0], ord[3][1:0]},
                 8'b10_10_10_10);
`endif
        tick();
        check_eq("arb_idle", busy, 0);

        // if_req pulsed only while busy must be ignored
        exe_req  = 1'b1;
        exe_addr = 18'h00023;
        tick();
        tick();
        if_req  = 1'b1;
        if_addr = 18'h00009;
        tick();
        if_req = 1'b0;
        n_if   = 0;
        n_exe  = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (if_ack) n_if++;
            if (exe_ack) begin n_exe++; exe_req = 1'b0; end
        end
        exe_req = 1'b0;
        check_eq("drop_early_no_if", n_if, 0);
        check_eq("drop_early_exe", n_exe, 1);

        // if_req dropped right after its grant still completes
        if_req = 1'b1;
        tick();
        if_req = 1'b0;
        check_eq("drop_late_busy", busy, 1);
        n_if = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (if_ack) n_if++;
        end
        check_eq("drop_late_ack", n_if, 1);
        check_eq("drop_late_rdata", if_rdata, 16'hA009);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Sequencer and arbiter for one shared asynchronous SRAM chip. It serves three requesters: bootloader image writes, EXE-stage loads/stores and IF-stage instruction fetches. For each granted request it runs a fixed multi-cycle access, generating the chip enable, output enable, write enable, address and tri-state data, and returns a one-cycle acknowledge with read data. It sits between the stall logic and the SRAM pins, replacing per-requester ad-hoc strobe generation.

## Interface
Parameters:
- ADDR_W, 18, SRAM address width
- DATA_W, 16, SRAM data width
- STROBE_CYCLES, 2, cycles OE/WE held low; legal range 1..7

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- boot_req  in  1  bootloader write request (level)
- boot_addr  in  ADDR_W  bootloader write address
- boot_data  in  DATA_W  bootloader write data
- boot_ack  out  1  one-cycle pulse: boot write complete
- exe_req  in  1  EXE access request (level)
- exe_we  in  1  1 = write, 0 = read
- exe_addr  in  ADDR_W  EXE address
- exe_wdata  in  DATA_W  EXE write data
- exe_ack  out  1  one-cycle pulse: EXE access complete
- exe_rdata  out  DATA_W  EXE read data; valid with exe_ack, held until the next EXE read completes
- if_req  in  1  fetch request (read only)
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle pulse: fetch complete
- if_rdata  out  DATA_W  fetched word; valid with if_ack, held until the next fetch completes
- sram_addr  out  ADDR_W  SRAM address
- sram_data  inout  DATA_W  SRAM data bus
- sram_en  out  1  chip enable, active-low
- sram_oe  out  1  output enable, active-low
- sram_we  out  1  write enable, active-low
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE → ADDR → STROBE → DONE → IDLE.
- IDLE:
  - Evaluate requests; if any is pending, register the grant ID, address, write flag and write data, then go to ADDR.
  - Requester inputs are not sampled after the grant.
- ADDR (1 cycle):
  - sram_en=0 and sram_addr is valid; OE and WE stay high.
  - For writes, sram_data is driven from this cycle onward.
- STROBE (STROBE_CYCLES cycles, down-counter):
  - Reads: sram_oe=0. Writes: sram_we=0.
  - On a read, sram_data is captured into the granted port's rdata register at the final STROBE edge.
- DONE (1 cycle):
  - Strobes are high and sram_en=0.
  - Write data is still driven, giving hold time after WE rises.
  - The granted port's ack=1.
  - Next state is IDLE.
- Priority:
  - boot highest, then exe, then if.
  - Boot requests are always writes.
- Request rules:
  - req is a level signal. A requester that keeps req high after its ack gets a new access, re-arbitrated in the next IDLE.
  - req dropped before the grant: the request is ignored.
  - req dropped after the grant: the access completes and ack still pulses.
  - Simultaneous requests: exactly one grant per IDLE; the losers wait with no ack.
- Bus control: sram_data is high-Z except during ADDR..DONE of a write.
- Reset values:
  - All ack outputs 0; busy 0; sram_en, sram_oe, sram_we all 1.
  - sram_addr 0; sram_data high-Z; exe_rdata and if_rdata 0; state IDLE.
- Reset mid-access:
  - The FSM returns to IDLE on the next edge and strobes rise immediately.
  - No ack is issued; an aborted write may be partial, and the requester re-issues it.

## Timing
- A request seen in IDLE at cycle 0 produces ADDR at cycle 1, STROBE at cycles 2..1+STROBE_CYCLES, and ack at cycle 2+STROBE_CYCLES (cycle 4 at the default).
- Back-to-back throughput is one access per 3+STROBE_CYCLES cycles.
- busy rises the cycle after the grant and falls the cycle after DONE.
- Acks are registered outputs; no combinational path runs from any req to any output.

## Configuration
- SRAM_ARB_RR_EN defined:
  - exe and if use round-robin.
  - A last-winner flip-flop, reset to "if" so that exe wins first, makes the loser of a contested grant win the next contested grant.
  - boot stays absolute highest.
- SRAM_ARB_RR_EN undefined: fixed priority boot > exe > if; no pointer flop.

## Structure
- Shared package contents:
  - State encoding (IDLE/ADDR/STROBE/DONE).
  - Grant IDs (GNT_NONE, GNT_BOOT, GNT_EXE, GNT_IF).
  - Default ADDR_W and DATA_W constants.
- One sub-module, sram_grant_sel: combinational picker.
  - Inputs: three reqs and, under SRAM_ARB_RR_EN, the last-winner bit.
  - Output: grant ID.
- FSM, counter, registers and tri-state live in the top.

## Test plan
- Reset: assert rst mid-STROBE of a write → next cycle sram_we=1, sram_en=1, bus high-Z, no ack, busy=0.
- Single read:
  - Stimulus: exe_req=1, exe_we=0, exe_addr=0x00123, SRAM model returns 0xBEEF.
  - Expected: sram_oe low at cycles 2–3; exe_ack high at cycle 4; exe_rdata=0xBEEF, held after ack.
- Single write:
  - Stimulus: boot_req with boot_addr=0x00010 and boot_data=0x1234.
  - Expected: sram_we low at cycles 2–3; data driven at cycles 1–4; boot_ack at cycle 4; memory model holds 0x1234.
- Contention: boot, exe and if all asserted and held → acks in order boot, exe, if; no overlapping strobes.
- Arbitration mode: exe and if held high continuously.
  - SRAM_ARB_RR_EN defined: acks alternate exe, if, exe, if.
  - SRAM_ARB_RR_EN undefined: exe acks only, and if is starved.
- Early drop: if_req pulses for one cycle while state ≠ IDLE → no grant and no if_ack. Dropping if_req after its grant → if_ack still pulses.
